usb_rcv_ctrl: RTL and testbench
===============================

# usb_rcv_ctrl

Receive control unit for the full-speed USB receiver. It runs the bit-sampling timer that produces `shift_enable` for the NRZI decoder and the receive shift register. It sequences each packet through SYNC check, byte collection, FIFO writes and EOP handling, and flags malformed packets. It sits between the edge/EOP detectors and the decoder, shift register and receive FIFO.

## Interface
- `CLKS_PER_BIT`, 8: system clocks per USB bit time.
- `SAMPLE_PT`, 3: timer count at which `shift_enable` pulses (1..`CLKS_PER_BIT`).
- `clk`  in  1  system clock.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `d_edge`  in  1  one-cycle pulse on any `d_plus` transition.
- `eop`  in  1  SE0 currently on bus (level).
- `rcv_data`  in  8  shift-register contents; LSB-first bits shifted in at the MSB.
- `shift_enable`  out  1  one-cycle bit-sample strobe to decoder and shift register.
- `rcving`  out  1  packet in progress.
- `w_enable`  out  1  one-cycle FIFO write strobe for `rcv_data`.
- `r_error`  out  1  sticky receive-error flag.

## Operation
- States:
  - `IDLE`: waiting for a packet.
  - `SYNC_RCV`: collecting the first byte.
  - `SYNC_CHK`: comparing the first byte against `SYNC_BYTE`.
  - `DATA_RCV`: collecting data bytes.
  - `STORE`: writing a completed byte to the FIFO.
  - `EOP_WAIT`: waiting for the bus to leave a good EOP.
  - `ERR_WAIT`: waiting for the bus to leave an errored packet.
  - `EIDLE`: idle with the error flag held.
- `IDLE`/`EIDLE`:
  - `d_edge` → `SYNC_RCV`.
  - The bit counter is cleared.
  - `EIDLE` → `SYNC_RCV` clears `r_error`.
- Bit counter: 0..7, increments on every `shift_enable`, wraps 7→0. A byte completes on the pulse that wraps it.
- `SYNC_RCV`:
  - Byte complete → `SYNC_CHK`.
  - `eop` at `shift_enable` → `ERR_WAIT`.
- `SYNC_CHK` (one cycle): `rcv_data == SYNC_BYTE` → `DATA_RCV`, else → `ERR_WAIT`.
- `DATA_RCV`, at `shift_enable`:
  - `eop` with bit counter 0 → `EOP_WAIT`. Zero-data packets are legal.
  - `eop` with bit counter ≠ 0 → `ERR_WAIT`. The partial byte is never written.
  - Otherwise, byte complete → `STORE`.
  - `eop` has priority over byte completion.
- `STORE` (one cycle): `w_enable`=1, → `DATA_RCV`.
- `EOP_WAIT`: `d_edge` (SE0→J) → `IDLE`.
- `ERR_WAIT`: `eop` seen, then `d_edge` → `EIDLE`.
- Outputs:
  - `rcving`=1 in `SYNC_RCV` through `ERR_WAIT`.
  - `r_error`=1 in `ERR_WAIT` and `EIDLE`.
  - `w_enable`=1 only in `STORE`.
  - All are Moore outputs decoded from the state register.
- Reset, asynchronous and valid in any state including mid-packet:
  - state → `IDLE`, timer 0, bit counter 0.
  - `shift_enable`, `rcving`, `w_enable`, `r_error` all 0.

## Timing
- Timer register `clk_cnt`:
  - Held at 0 in `IDLE`/`EIDLE`.
  - Loads 1 on the cycle after any `d_edge` while not in `IDLE`/`EIDLE` or while leaving them. This is edge resync.
  - Otherwise counts 1..`CLKS_PER_BIT` and wraps to 1.
- `shift_enable` = (`clk_cnt == SAMPLE_PT`), driven from the register.
  - Timing: `d_edge` in cycle 0 → `clk_cnt`=1 in cycle 1 → `shift_enable` in cycle `SAMPLE_PT` (3), then every `CLKS_PER_BIT` cycles: 3, 11, 19, …
  - If `d_edge` coincides with `clk_cnt == SAMPLE_PT`, the strobe still fires that cycle and the counter reloads to 1.
- Byte hand-off:
  - The shift register updates on the 8th `shift_enable` edge.
  - `SYNC_CHK`/`STORE` occupy the following cycle, when `rcv_data` is stable.
  - FIFO write latency is one cycle after the completing strobe.
- The timer keeps running in `EOP_WAIT`/`ERR_WAIT` so the decoder sees strobes during EOP.

## Structure
- Package `usb_rcv_pkg`:
  - state enum `rcv_state_t`.
  - `SYNC_BYTE = 8'h80`.
  - bit-counter width constant.
- Sub-module `rcv_bit_timer`: `clk_cnt` with resync plus the 0..7 bit counter.
  - Inputs: `enable`, `resync`, `clear`.
  - Outputs: `shift_enable`, `byte_done`.
- The FSM stays in `usb_rcv_ctrl`.

## Test plan
- Reset: assert `n_rst` in `DATA_RCV` mid-byte → all outputs 0 in the same cycle. The next `d_edge` restarts at `SYNC_RCV` with the strobe 3 cycles later.
- Good packet: SYNC (`rcv_data`=8'h80), one byte 8'hA5, EOP on the boundary:
  - Strobes at cycles 3, 11, …, 123.
  - `w_enable` exactly once, the cycle after strobe 16.
  - `rcving` falls the cycle after the SE0→J edge.
  - `r_error` stays 0.
- Bad SYNC: `rcv_data`=8'h81 → `r_error`=1 from the cycle after `SYNC_CHK`, no `w_enable`, `rcving` held until EOP ends. `r_error` stays 1 in `EIDLE`.
- Early EOP: `eop` at the strobe with bit counter 3 → `ERR_WAIT`, no `w_enable` for the partial byte.
- Resync: bit edge arrives at cycle 9 instead of 8 → `clk_cnt`=1 at cycle 10, next strobe at cycle 12, not 11.
- Recovery: errored packet then good packet → `r_error` clears the cycle after the first `d_edge` of the second packet. The second packet's byte is written normally.

Source files
------------

// File: rtl/usb_rcv_pkg.sv
// Shared types and constants for the USB receive control slice.
package usb_rcv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC_RCV,
    SYNC_CHK,
    DATA_RCV,
    STORE,
    EOP_WAIT,
    ERR_WAIT,
    EIDLE
  } rcv_state_t;

  localparam logic [7:0]  SYNC_BYTE = 8'h80;
  localparam int unsigned BIT_CNT_W = 3;

  function automatic logic is_idle(input rcv_state_t s);
    return (s == IDLE) || (s == EIDLE);
  endfunction

endpackage

// File: rtl/rcv_bit_timer.sv
// Bit-sampling timer with edge resync, plus the bit-within-byte counter.
module rcv_bit_timer
  import usb_rcv_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SAMPLE_PT    = 3
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 enable,
  input  logic                 resync,
  input  logic                 clear,
  output logic                 shift_enable,
  output logic                 byte_done,
  output logic [BIT_CNT_W-1:0] bit_cnt
);

  localparam int unsigned      CNT_W      = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_PT);

  logic [CNT_W-1:0] clk_cnt;
  logic [CNT_W-1:0] clk_cnt_next;

  // Resync wins over everything, so the edge that leaves idle also starts the count.
  always_comb begin
    clk_cnt_next = clk_cnt;
    if (resync)
      clk_cnt_next = CNT_ONE;
    else if (!enable)
      clk_cnt_next = '0;
    else if (clk_cnt >= CNT_MAX)
      clk_cnt_next = CNT_ONE;
    else
      clk_cnt_next = clk_cnt + CNT_ONE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt_next;
      if (clear)
        bit_cnt <= '0;
      else if (shift_enable)
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end
  end

  assign shift_enable = (clk_cnt == CNT_SAMPLE);
  assign byte_done    = shift_enable && (bit_cnt == '1);

endmodule

// File: rtl/usb_rcv_ctrl.sv
// Receive control FSM: SYNC check, byte collection, FIFO writes and EOP/error handling.
module usb_rcv_ctrl
  import usb_rcv_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SAMPLE_PT    = 3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic [7:0] rcv_data,
  output logic       shift_enable,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error
);

  rcv_state_t           state;
  rcv_state_t           state_next;
  logic                 eop_seen;
  logic                 in_idle;
  logic                 byte_done;
  logic [BIT_CNT_W-1:0] bit_cnt;

  assign in_idle = is_idle(state);

  rcv_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SAMPLE_PT    (SAMPLE_PT)
  ) u_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable       (!in_idle),
    .resync       (d_edge),
    .clear        (in_idle),
    .shift_enable (shift_enable),
    .byte_done    (byte_done),
    .bit_cnt      (bit_cnt)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE, EIDLE:
        if (d_edge) state_next = SYNC_RCV;
      SYNC_RCV:
        if (shift_enable && eop) state_next = ERR_WAIT;
        else if (byte_done)      state_next = SYNC_CHK;
      SYNC_CHK:
        state_next = (rcv_data == SYNC_BYTE) ? DATA_RCV : ERR_WAIT;
      DATA_RCV:
        if (shift_enable && eop)
          state_next = (bit_cnt == '0) ? EOP_WAIT : ERR_WAIT;
        else if (byte_done)
          state_next = STORE;
      STORE:
        state_next = DATA_RCV;
      EOP_WAIT:
        if (d_edge) state_next = IDLE;
      ERR_WAIT:
        if (d_edge && eop_seen) state_next = EIDLE;
      default:
        state_next = IDLE;
    endcase
  end

  // An edge in ERR_WAIT only ends the packet once SE0 has been observed, so the
  // edge into SE0 itself is not mistaken for the SE0->J edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      eop_seen <= 1'b0;
    end else begin
      state    <= state_next;
      eop_seen <= (state_next == ERR_WAIT) && (eop_seen || eop);
    end
  end

  assign rcving   = (state != IDLE) && (state != EIDLE);
  assign r_error  = (state == ERR_WAIT) || (state == EIDLE);
  assign w_enable = (state == STORE);

endmodule

// File: tb/tb_usb_rcv_ctrl.sv
// Scoreboard bench for usb_rcv_ctrl: bit-level packet timelines drive the DUT, expectations queued per packet.
module tb_usb_rcv_ctrl;

  localparam int CPB = 8;
  localparam int SP  = 3;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_edge;
  logic       eop;
  logic [7:0] rcv_data;
  logic       shift_enable;
  logic       rcving;
  logic       w_enable;
  logic       r_error;

  usb_rcv_ctrl #(
    .CLKS_PER_BIT (CPB),
    .SAMPLE_PT    (SP)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_edge       (d_edge),
    .eop          (eop),
    .rcv_data     (rcv_data),
    .shift_enable (shift_enable),
    .rcving       (rcving),
    .w_enable     (w_enable),
    .r_error      (r_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    int   cyc;
    logic rcving;
    logic r_error;
  } lvl_t;

  int   sq[$];
  wr_t  wq[$];
  lvl_t lq[$];
  int   checks = 0;
  int   errors = 0;
  bit   prev_err = 1'b0;

  // Monitor: pops expectations whenever the DUT presents a strobe/write or a level check is due.
  always @(negedge clk) begin
    while (sq.size() > 0 && sq[0] < cyc) begin
      checks++; errors++;
      $display("FAIL strobe_missed cycle %0d got shift_enable=0 required 1", sq[0]);
      void'(sq.pop_front());
    end
    if (shift_enable) begin
      checks++;
      if (sq.size() > 0 && sq[0] == cyc) void'(sq.pop_front());
      else begin
        errors++;
        $display("FAIL strobe_unexpected cycle %0d got shift_enable=1 required 0", cyc);
      end
    end
    while (wq.size() > 0 && wq[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL write_missed cycle %0d got w_enable=0 required 1 (data %h)", wq[0].cyc, wq[0].data);
      void'(wq.pop_front());
    end
    if (w_enable) begin
      checks++;
      if (wq.size() > 0 && wq[0].cyc == cyc) begin
        if (rcv_data !== wq[0].data) begin
          errors++;
          $display("FAIL write_data cycle %0d got %h required %h", cyc, rcv_data, wq[0].data);
        end
        void'(wq.pop_front());
      end else begin
        errors++;
        $display("FAIL write_unexpected cycle %0d got w_enable=1 required 0", cyc);
      end
    end
    while (lq.size() > 0 && lq[0].cyc <= cyc) begin
      if (lq[0].cyc == cyc) begin
        checks++;
        if (rcving !== lq[0].rcving || r_error !== lq[0].r_error) begin
          errors++;
          $display("FAIL levels cycle %0d got rcving=%b r_error=%b required rcving=%b r_error=%b",
                   cyc, rcving, r_error, lq[0].rcving, lq[0].r_error);
        end
      end
      void'(lq.pop_front());
    end
  end

  function automatic void push_lvl(input int c, input logic r, input logic e);
    lvl_t l;
    l.cyc = c; l.rcving = r; l.r_error = e;
    lq.push_back(l);
  endfunction

  // kind: 0 good, 1 bad SYNC, 2 EOP after kb bits of data byte mk, 3 EOP after kb SYNC bits.
  // Every bit starts at s[i]; it is sampled SP cycles later. Edges may move a bit start by -1/+1.
  task automatic run_packet(input int kind, input int nb, input int mk, input int kb,
                            input logic [7:0] sync, input logic [7:0] d0,
                            input bit jit, input bit late1, input int abort_bit);
    logic [7:0] data [4];
    logic       bits [$];
    int         s [$];
    bit         e [$];
    int         len, t0, lim, endc, p, nw, c;
    logic [7:0] rd;
    bit         err;
    wr_t        w;

    for (int b = 0; b < 4; b++) data[b] = 8'($urandom);
    data[0] = d0;
    case (kind)
      0, 1:    len = 8 + 8 * nb;
      2:       len = 8 + 8 * mk + kb;
      default: len = kb;
    endcase
    for (int i = 0; i < len; i++) begin
      logic [7:0] byt;
      byt = (i < 8) ? sync : data[(i - 8) / 8];
      bits.push_back(byt[i % 8]);
    end
    s.push_back(0); e.push_back(1'b1);
    for (int i = 1; i <= len + 2; i++) begin
      bit ed;
      int dl;
      ed = (i == len + 2) || (i == 1 && late1) || (i != len + 1 && $urandom_range(1, 0) == 1);
      dl = CPB;
      if (i == 1 && late1) dl = CPB + 1;
      else if (ed && jit && $urandom_range(3, 0) == 0) dl = int'($urandom_range(CPB + 1, CPB - 1));
      s.push_back(s[i - 1] + dl);
      e.push_back(ed);
    end
    err  = (kind >= 2) || (sync != 8'h80);
    endc = s[len + 2];
    lim  = (abort_bit >= 0) ? s[abort_bit] + SP : endc + 2;

    @(posedge clk); #1;
    t0 = cyc;
    for (int i = 0; i <= len + 1; i++)
      if (s[i] + SP < lim) sq.push_back(t0 + s[i] + SP);
    nw = (kind == 0) ? nb : (kind == 2) ? mk : 0;
    for (int b = 0; b < nw; b++) begin
      c = s[15 + 8 * b] + SP + 1;
      if (c < lim) begin
        w.cyc = t0 + c; w.data = data[b];
        wq.push_back(w);
      end
    end
    push_lvl(t0, 1'b0, prev_err);
    if (1 < lim) push_lvl(t0 + 1, 1'b1, 1'b0);
    if (kind == 1) begin
      c = s[7] + SP + 1;
      if (c + 1 < lim) begin
        push_lvl(t0 + c, 1'b1, 1'b0);
        push_lvl(t0 + c + 1, 1'b1, 1'b1);
      end
    end
    if (endc + 1 < lim) begin
      push_lvl(t0 + endc, 1'b1, err);
      push_lvl(t0 + endc + 1, 1'b0, err);
    end
    if (abort_bit >= 0) push_lvl(t0 + lim, 1'b0, 1'b0);

    rd = rcv_data;
    p  = 0;
    for (int cc = 0; cc <= endc; cc++) begin
      if (cc > 0) begin @(posedge clk); #1; end
      if (p <= len + 1 && cc == s[p] + SP + 1) begin
        rd = {(p < len) ? bits[p] : 1'b0, rd[7:1]};
        p++;
      end
      d_edge = 1'b0;
      for (int i = 0; i <= len + 2; i++)
        if (e[i] && s[i] == cc) d_edge = 1'b1;
      eop      = (cc >= s[len]) && (cc < s[len + 2]);
      rcv_data = rd;
      if (abort_bit >= 0 && cc == lim) begin
        n_rst = 1'b0;
        break;
      end
    end
    if (abort_bit >= 0) begin
      repeat (2) @(posedge clk);
      #1;
      d_edge = 1'b0; eop = 1'b0; n_rst = 1'b1;
      prev_err = 1'b0;
    end else begin
      prev_err = err;
    end
    @(posedge clk); #1;
    d_edge = 1'b0; eop = 1'b0;
    repeat ($urandom_range(8, 3)) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (sq.size() != 0 || wq.size() != 0 || lq.size() != 0) begin
      errors++;
      $display("FAIL drain got pending strobe=%0d write=%0d level=%0d required 0",
               sq.size(), wq.size(), lq.size());
      sq.delete(); wq.delete(); lq.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish by cycle %0d required completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int         kind, nb, mk, kb;
    logic [7:0] sy;
    n_rst = 1'b0; d_edge = 1'b0; eop = 1'b0; rcv_data = 8'h00;
    push_lvl(2, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (2) @(posedge clk);

    run_packet(0, 1, 0, 0, 8'h80, 8'hA5, 1'b0, 1'b0, -1);
    run_packet(1, 1, 0, 0, 8'h81, 8'h3C, 1'b0, 1'b0, -1);
    run_packet(0, 1, 0, 0, 8'h80, 8'h5A, 1'b0, 1'b1, -1);
    run_packet(2, 2, 0, 3, 8'h80, 8'h77, 1'b0, 1'b0, -1);
    run_packet(0, 0, 0, 0, 8'h80, 8'h00, 1'b0, 1'b0, -1);
    run_packet(3, 0, 0, 5, 8'h80, 8'h00, 1'b0, 1'b0, -1);
    run_packet(0, 2, 0, 0, 8'h80, 8'hC3, 1'b0, 1'b0, 12);
    run_packet(0, 1, 0, 0, 8'h80, 8'h96, 1'b0, 1'b0, -1);

    for (int n = 0; n < 30; n++) begin
      kind = int'($urandom_range(3, 0));
      nb   = int'($urandom_range(3, 0));
      mk   = int'($urandom_range(3, 0));
      kb   = int'($urandom_range(7, 1));
      sy   = 8'h80;
      if (kind == 1) begin
        sy = 8'($urandom);
        if (sy == 8'h80) sy = 8'h00;
      end
      run_packet(kind, nb, mk, kb, sy, 8'($urandom), 1'b1, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
